// File: rtl/bit_serializer_pkg.sv
// Shared constants for the serializer and the downstream "111" sequence detector.
package bit_serializer_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef logic [0:0] ser_state_t;
  localparam ser_state_t ST_IDLE  = 1'b0;
  localparam ser_state_t ST_SHIFT = 1'b1;

  // Moore detector states: number of consecutive ones seen, saturating at three
  typedef logic [1:0] det_state_t;
  localparam det_state_t DET_S0 = 2'd0;
  localparam det_state_t DET_S1 = 2'd1;
  localparam det_state_t DET_S2 = 2'd2;
  localparam det_state_t DET_S3 = 2'd3;

  function automatic int cnt_bits(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/bit_serializer_hold.sv
// One-entry holding register between the parallel input and the shifter.
module hold_buf
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             take,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  // load and take are mutually exclusive: load needs empty, take needs full
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
      full <= 1'b0;
    end else if (load) begin
      data <= din;
      full <= 1'b1;
    end else if (take) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word holding register for gapless streaming.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             w,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_bits(WIDTH);

  ser_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shnext;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             load;
  logic             take;

  assign din_ready = !hold_full;
  assign load      = din_valid && !hold_full;
  // cnt is zero in IDLE, so this covers both the first load and the back-to-back reload
  assign take      = hold_full && (cnt == '0);
  assign busy      = (state == ST_SHIFT);
  assign done      = busy && (cnt == '0);

  hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .take  (take),
    .din   (din),
    .data  (hold_data),
    .full  (hold_full)
  );

  function automatic logic first_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  // Rotate rather than shift so every bit stays live; cnt decides when the word ends
  always_comb begin
    shnext = shreg;
    if (take) begin
      shnext = hold_data;
    end else if (MSB_FIRST) begin
      shnext = {shreg[WIDTH-2:0], shreg[WIDTH-1]};
    end else begin
      shnext = {shreg[0], shreg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      shreg <= '0;
      w     <= IDLE_BIT;
    end else if (take) begin
      state <= ST_SHIFT;
      cnt   <= CW'(WIDTH - 1);
      shreg <= shnext;
      w     <= first_bit(shnext);
    end else if (state == ST_SHIFT && cnt != '0) begin
      cnt   <= cnt - CW'(1);
      shreg <= shnext;
      w     <= first_bit(shnext);
    end else begin
      state <= ST_IDLE;
      w     <= IDLE_BIT;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench: an MSB-first and an LSB-first serializer plus a "111" detector model on the MSB stream.
module tb_bit_serializer;
  import bit_serializer_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] dinA = '0;
  logic [7:0] dinB = '0;
  logic       validA = 1'b0;
  logic       validB = 1'b0;
  logic       readyA, wA, busyA, doneA;
  logic       readyB, wB, busyB, doneB;

  int         total = 0;
  int         bad = 0;
  logic [1:0] expA[$];
  logic [1:0] expB[$];
  det_state_t detState;
  logic       z;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .reset(reset), .din(dinA), .din_valid(validA),
    .din_ready(readyA), .w(wA), .busy(busyA), .done(doneA)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .din(dinB), .din_valid(validB),
    .din_ready(readyB), .w(wB), .busy(busyB), .done(doneB)
  );

  // Downstream detector: z while the last three sampled bits of wA were all ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) detState <= DET_S0;
    else begin
      case (detState)
        DET_S0:  detState <= wA ? DET_S1 : DET_S0;
        DET_S1:  detState <= wA ? DET_S2 : DET_S0;
        DET_S2:  detState <= wA ? DET_S3 : DET_S0;
        default: detState <= wA ? DET_S3 : DET_S0;
      endcase
    end
  end
  assign z = (detState == DET_S3);

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushExpected(input logic [7:0] data, input bit sel);
    for (int i = 0; i < 8; i++) begin
      logic b;
      b = sel ? data[i] : data[7-i];
      if (sel) expB.push_back({b, (i == 7)});
      else     expA.push_back({b, (i == 7)});
    end
  endtask

  // Present data until accepted; junk is driven on din while the DUT is not ready
  task automatic applyStimulus(input logic [7:0] data, input logic [7:0] junk,
                               input bit keep, input bit sel, output int waited);
    waited = 0;
    if (sel) validB = 1'b1; else validA = 1'b1;
    while (!(sel ? readyB : readyA) && waited < 50) begin
      if (sel) dinB = junk; else dinA = junk;
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      checkOutput("accept timeout", waited, 0);
      if (sel) validB = 1'b0; else validA = 1'b0;
      return;
    end
    if (sel) dinB = data; else dinA = data;
    pushExpected(data, sel);
    @(posedge clk);
    #1;
    if (!keep) begin
      if (sel) validB = 1'b0; else validA = 1'b0;
    end
  endtask

  task automatic waitIdle(input bit sel);
    int n;
    n = 0;
    while ((sel ? (expB.size() != 0 || busyB) : (expA.size() != 0 || busyA)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput(sel ? "B drain" : "A drain", sel ? expB.size() : expA.size(), 0);
  endtask

  // Monitors: pop one expected {w,done} per busy cycle, otherwise require idle outputs
  always @(negedge clk) begin
    if (!reset) begin
      if (busyA) begin
        if (expA.size() == 0) checkOutput("A unexpected bit", 1, 0);
        else checkOutput("A bit {w,done}", {wA, doneA}, expA.pop_front());
      end else begin
        checkOutput("A idle {w,done}", {wA, doneA}, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (busyB) begin
        if (expB.size() == 0) checkOutput("B unexpected bit", 1, 0);
        else checkOutput("B bit {w,done}", {wB, doneB}, expB.pop_front());
      end else begin
        checkOutput("B idle {w,done}", {wB, doneB}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int waited;
    int busyCount;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset w", wA, 0);
    checkOutput("reset busy", busyA, 0);
    checkOutput("reset done", doneA, 0);
    checkOutput("reset ready", readyA, 1);
    checkOutput("reset B ready", readyB, 1);
    @(negedge clk);
    #2 reset = 1'b0;

    // Single word right after reset: accepted first edge, done only on cycle k+8
    applyStimulus(8'hA5, 8'hA5, 1'b0, 1'b0, waited);
    checkOutput("first accept wait", waited, 0);
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      checkOutput("latency busy", busyA, (c >= 1 && c <= 8) ? 1 : 0);
      checkOutput("latency done", doneA, (c == 8) ? 1 : 0);
    end
    waitIdle(1'b0);

    applyStimulus(8'h01, 8'h01, 1'b0, 1'b1, waited);
    applyStimulus(8'hB4, 8'hB4, 1'b0, 1'b1, waited);
    waitIdle(1'b1);

    // Back-to-back with valid held high
    applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0, waited);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, waited);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      checkOutput("b2b busy", busyA, 1);
      checkOutput("b2b ready", readyA, (i < 7) ? 0 : 1);
    end
    waitIdle(1'b0);

    // Stall: third word waits while hold is full, junk on din must not be captured
    applyStimulus(8'h3C, 8'h3C, 1'b1, 1'b0, waited);
    applyStimulus(8'hC3, 8'hC3, 1'b1, 1'b0, waited);
    applyStimulus(8'h96, 8'h55, 1'b0, 1'b0, waited);
    checkOutput("stall wait", waited, 8);
    waitIdle(1'b0);

    // Integration with the detector
    repeat (3) @(negedge clk);
    applyStimulus(8'hE0, 8'hE0, 1'b0, 1'b0, waited);
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      checkOutput("detector z", z, (c == 4) ? 1 : 0);
    end
    waitIdle(1'b0);

    // Reset mid-word with a second word held
    applyStimulus(8'h5A, 8'h5A, 1'b1, 1'b0, waited);
    applyStimulus(8'hC6, 8'hC6, 1'b0, 1'b0, waited);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    expA.delete();
    expB.delete();
    #1;
    checkOutput("midreset w", wA, 0);
    checkOutput("midreset busy", busyA, 0);
    checkOutput("midreset done", doneA, 0);
    checkOutput("midreset ready", readyA, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    busyCount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busyA) busyCount++;
    end
    checkOutput("post-reset busy cycles", busyCount, 0);
    waitIdle(1'b0);
    waitIdle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.
REQ-003 SHALL have parameter IDLE_BIT, default 0, giving the level driven on w when no word is shifting.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port din, input, WIDTH bits: the parallel word to serialize.
REQ-007 SHALL have port din_valid, input, 1 bit: din is valid this cycle.
REQ-008 SHALL have port din_ready, output, 1 bit: the block can accept din this cycle.
REQ-009 SHALL have port w, output, 1 bit: registered serial bit stream for the downstream sequence detector.
REQ-010 SHALL have port busy, output, 1 bit: a word is currently on w.
REQ-011 SHALL have port done, output, 1 bit: high during the cycle the last bit of a word is on w.

Function
REQ-012 SHALL transfer a word on a rising edge where din_valid=1 and din_ready=1; data SHALL be captured into a one-entry holding register (hold_full <= 1).
REQ-013 SHALL drive din_ready = !hold_full, taken from a flop with no combinational path from din_valid.
REQ-014 SHALL use an FSM with states IDLE and SHIFT and a down-counter cnt of width clog2(WIDTH).
REQ-015 In IDLE with hold_full=1: next edge SHALL load the shift register from hold, set cnt=WIDTH-1, clear hold_full, and enter SHIFT.
REQ-016 In SHIFT with cnt>0: each edge SHALL shift one bit toward w and decrement cnt.
REQ-017 In SHIFT with cnt=0 and hold_full=1: next edge SHALL reload from hold with no idle gap (back-to-back words).
REQ-018 In SHIFT with cnt=0 and hold_full=0: next edge SHALL enter IDLE.
REQ-019 Latency SHALL be: word accepted at edge k while IDLE -> first bit on w from edge k+1, last bit from edge k+WIDTH.
REQ-020 w SHALL equal IDLE_BIT whenever the state is IDLE.
REQ-021 busy SHALL be 1 exactly when the state is SHIFT.
REQ-022 done SHALL be 1 exactly when the state is SHIFT and cnt=0.
REQ-023 A word accepted on the same edge that hold empties into the shifter is impossible by construction (din_ready=0 that cycle); no data SHALL be lost or duplicated.
REQ-024 Sustained throughput SHALL be one word per WIDTH cycles with w never returning to IDLE_BIT between queued words.
REQ-025 din SHALL be ignored when din_ready=0 or din_valid=0.

Reset
REQ-026 reset=1 SHALL immediately set state=IDLE, cnt=0, hold_full=0, and w=IDLE_BIT, which also gives busy=0, done=0 and din_ready=1.
REQ-027 Reset mid-word SHALL discard both the shifting word and any held word; no partial bits SHALL follow reset deassertion.
REQ-028 The first acceptance SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-029 A shared package SHALL hold the state encodings (IDLE, SHIFT) and the WIDTH default; the downstream detector's state constants SHALL live there too.
REQ-030 The one-entry holding register SHALL be a sub-module hold_buf (data, full, load, take); the FSM, counter and shifter SHALL stay in bit_serializer.

Verification
REQ-031 Reset check: assert reset mid-word with hold_full=1 -> w=IDLE_BIT, busy=0, din_ready=1 immediately; nothing is emitted after release.
REQ-032 Single-word check: WIDTH=8, MSB_FIRST=1, din=8'hA5 at edge k -> w=1,0,1,0,0,1,0,1 on cycles k+1..k+8; done only on cycle k+8; w=0 from k+9.
REQ-033 LSB-first check: MSB_FIRST=0, din=8'h01 -> w=1 then seven 0s.
REQ-034 Back-to-back check: din_valid held high with 8'hFF then 8'h00 -> 16 contiguous bits 1x8 then 0x8; busy continuously 1; din_ready low between acceptances.
REQ-035 Integration check: feed the downstream sequence detector with 8'hE0, MSB-first -> w=1,1,1 on cycles k+1..k+3; detector z=1 on cycle k+4 only.
REQ-036 Stall check: din_valid=1 while din_ready=0 -> din is not captured; the word is accepted on the first cycle din_ready returns to 1.
